// File: rtl/seq_detect_pkg.sv
// Shared definitions for the programmable sequence detector: FSM encoding,
// default sizing and the configuration length clamp.
package seq_detect_pkg;

  localparam int DEF_MAX_LEN = 8;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_UNARMED = 2'd0,
    ST_FILL    = 2'd1,
    ST_HUNT    = 2'd2
  } state_t;

  function automatic int clamp_len(input int len, input int max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/seq_detect_prog_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_inc,
  input  logic         i_clear,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/seq_detect_prog.sv
// Programmable Moore serial sequence detector with runtime-loadable pattern,
// overlap control, sample qualifier and saturating detection count.
//
//   state      | meaning
//   ST_UNARMED | stored length is 0, samples ignored
//   ST_FILL    | fewer than len valid samples since load/last non-overlap hit
//   ST_HUNT    | window full, every valid sample is compared
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter  int MAX_LEN = DEF_MAX_LEN,
  parameter  int CNT_W   = DEF_CNT_W,
  localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               seq_in,
  input  logic               seq_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               det_o,
  output logic [CNT_W-1:0]   det_count,
  output logic               armed_o
);

  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  state_t             r_state;
  logic               r_det;

  logic [LEN_W-1:0]   w_len_clamp;
  logic [MAX_LEN-1:0] w_mask;
  logic [MAX_LEN-1:0] w_cand;
  logic [LEN_W:0]     w_fill_inc;
  logic               w_full;
  logic               w_sample;
  logic               w_match;

  assign w_len_clamp = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  assign w_cand     = {r_hist[MAX_LEN-2:0], seq_in};
  assign w_fill_inc = {1'b0, r_fill} + (LEN_W + 1)'(1);
  assign w_full     = (w_fill_inc >= {1'b0, r_len});
  // A load on the same edge takes priority, so the sample is dropped.
  assign w_sample   = seq_valid && !cfg_load && (r_state != ST_UNARMED);
  assign w_match    = w_sample && w_full && (((w_cand ^ r_pat) & w_mask) == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pat   <= '0;
      r_len   <= '0;
      r_ovl   <= 1'b0;
      r_hist  <= '0;
      r_fill  <= '0;
      r_state <= ST_UNARMED;
      r_det   <= 1'b0;
    end else if (cfg_load) begin
      r_pat   <= cfg_pattern;
      r_len   <= w_len_clamp;
      r_ovl   <= cfg_overlap;
      r_hist  <= '0;
      r_fill  <= '0;
      r_det   <= 1'b0;
      r_state <= (w_len_clamp == '0) ? ST_UNARMED : ST_FILL;
    end else begin
      r_det <= w_match;
      if (w_sample) begin
        r_hist <= w_cand;
        if (w_match && !r_ovl) begin
          r_fill  <= '0;
          r_state <= ST_FILL;
        end else if (r_state == ST_FILL) begin
          r_fill <= w_fill_inc[LEN_W-1:0];
          if (w_full) begin
            r_state <= ST_HUNT;
          end
        end
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .i_inc   (w_match),
    .i_clear (cfg_load),
    .o_count (det_count)
  );

  assign det_o   = r_det;
  assign armed_o = (r_len != '0);

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: vector table for the main detection
// scenarios plus hand sequences for saturation, async reset and load priority.
module tb_seq_detect_prog;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        seq_in, seq_valid, cfg_load, cfg_overlap;
  logic [7:0]  cfg_pattern;
  logic [3:0]  cfg_len;
  logic        det_o, armed_o;
  logic [15:0] det_count;

  logic        s_in, s_valid, s_load, s_ovl;
  logic [7:0]  s_pat;
  logic [3:0]  s_len;
  logic        s_det, s_armed;
  logic [1:0]  s_count;

  seq_detect_prog dut (
    .clock       (clock),
    .reset       (reset),
    .seq_in      (seq_in),
    .seq_valid   (seq_valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .det_o       (det_o),
    .det_count   (det_count),
    .armed_o     (armed_o)
  );

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut_small (
    .clock       (clock),
    .reset       (reset),
    .seq_in      (s_in),
    .seq_valid   (s_valid),
    .cfg_load    (s_load),
    .cfg_pattern (s_pat),
    .cfg_len     (s_len),
    .cfg_overlap (s_ovl),
    .det_o       (s_det),
    .det_count   (s_count),
    .armed_o     (s_armed)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  typedef struct {
    logic        load;
    logic [7:0]  pat;
    logic [3:0]  len;
    logic        ovl;
    logic        valid;
    logic        b;
    logic        edet;
    logic [15:0] ecnt;
    logic        earmed;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk_cfg(input logic [7:0] pat, input logic [3:0] len,
                                  input logic ovl, input logic earmed);
    vec_t v;
    v.load = 1'b1; v.pat = pat; v.len = len; v.ovl = ovl;
    v.valid = 1'b0; v.b = 1'b0; v.edet = 1'b0; v.ecnt = 16'd0; v.earmed = earmed;
    return v;
  endfunction

  function automatic vec_t mk_smp(input logic valid, input logic b, input logic edet,
                                  input logic [15:0] ecnt, input logic earmed);
    vec_t v;
    v.load = 1'b0; v.pat = 8'h00; v.len = 4'd0; v.ovl = 1'b0;
    v.valid = valid; v.b = b; v.edet = edet; v.ecnt = ecnt; v.earmed = earmed;
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    seq_in = 0; seq_valid = 0; cfg_load = 0; cfg_overlap = 0;
    cfg_pattern = '0; cfg_len = '0;
    s_in = 0; s_valid = 0; s_load = 0; s_ovl = 0; s_pat = '0; s_len = '0;

    // 101 overlapping: hits on bits 3 and 5
    vecs.push_back(mk_cfg(8'b101, 4'd3, 1'b1, 1'b1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 1, 1, 1));
    vecs.push_back(mk_smp(1, 0, 0, 1, 1));
    vecs.push_back(mk_smp(1, 1, 1, 2, 1));
    // 101 non-overlapping: only bit 3
    vecs.push_back(mk_cfg(8'b101, 4'd3, 1'b0, 1'b1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 1, 1, 1));
    vecs.push_back(mk_smp(1, 0, 0, 1, 1));
    vecs.push_back(mk_smp(1, 1, 0, 1, 1));
    // 1011 overlapping on 1011011: bits 4 and 7
    vecs.push_back(mk_cfg(8'b1011, 4'd4, 1'b1, 1'b1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 1, 1, 1));
    vecs.push_back(mk_smp(1, 0, 0, 1, 1));
    vecs.push_back(mk_smp(1, 1, 0, 1, 1));
    vecs.push_back(mk_smp(1, 1, 1, 2, 1));
    // 1011 on 1010: nothing
    vecs.push_back(mk_cfg(8'b1011, 4'd4, 1'b1, 1'b1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    // 101 with invalid gaps carrying a 1 on seq_in
    vecs.push_back(mk_cfg(8'b101, 4'd3, 1'b1, 1'b1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(0, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(0, 1, 0, 0, 1));
    vecs.push_back(mk_smp(0, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 1, 1, 1));
    vecs.push_back(mk_smp(0, 1, 0, 1, 1));
    // length 15 clamps to 8: 10110011 hits only on the 8th bit
    vecs.push_back(mk_cfg(8'b10110011, 4'd15, 1'b1, 1'b1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(1, 0, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 0, 0, 1));
    vecs.push_back(mk_smp(1, 1, 1, 1, 1));
    // length 0 disarms
    vecs.push_back(mk_cfg(8'b1, 4'd0, 1'b1, 1'b0));
    vecs.push_back(mk_smp(1, 1, 0, 0, 0));
    vecs.push_back(mk_smp(1, 1, 0, 0, 0));

    #12;
    check("rst_det", 0, 32'(det_o), 32'd0);
    check("rst_cnt", 0, 32'(det_count), 32'd0);
    check("rst_armed", 0, 32'(armed_o), 32'd0);
    check("rst_small_cnt", 0, 32'(s_count), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      cfg_load    = vecs[i].load;
      cfg_pattern = vecs[i].pat;
      cfg_len     = vecs[i].len;
      cfg_overlap = vecs[i].ovl;
      seq_valid   = vecs[i].valid;
      seq_in      = vecs[i].b;
      tick();
      check("vec_det", i, 32'(det_o), 32'(vecs[i].edet));
      check("vec_cnt", i, 32'(det_count), 32'(vecs[i].ecnt));
      check("vec_armed", i, 32'(armed_o), 32'(vecs[i].earmed));
    end
    cfg_load = 0; seq_valid = 0;

    // CNT_W=2 saturation with a length-1 pattern
    s_load = 1; s_pat = 8'h01; s_len = 4'd1; s_ovl = 1;
    tick();
    check("sat_armed", 0, 32'(s_armed), 32'd1);
    s_load = 0; s_valid = 1; s_in = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("sat_det", k, 32'(s_det), 32'd1);
      check("sat_cnt", k, 32'(s_count), (k < 3) ? 32'(k + 1) : 32'd3);
    end
    s_in = 0;
    tick();
    check("sat_det_zero", 0, 32'(s_det), 32'd0);
    check("sat_cnt_hold", 0, 32'(s_count), 32'd3);
    s_valid = 0;

    // async reset cancels an in-flight pulse
    cfg_load = 1; cfg_pattern = 8'b101; cfg_len = 4'd3; cfg_overlap = 1;
    tick();
    cfg_load = 0; seq_valid = 1;
    seq_in = 1; tick();
    seq_in = 0; tick();
    seq_in = 1; tick();
    check("pre_rst_det", 0, 32'(det_o), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_det", 0, 32'(det_o), 32'd0);
    check("arst_cnt", 0, 32'(det_count), 32'd0);
    check("arst_armed", 0, 32'(armed_o), 32'd0);
    #3 reset = 1'b0;
    seq_in = 1; tick();
    check("post_rst_det", 0, 32'(det_o), 32'd0);
    seq_in = 0; tick();
    seq_in = 1; tick();
    check("post_rst_det", 1, 32'(det_o), 32'd0);
    check("post_rst_cnt", 0, 32'(det_count), 32'd0);
    seq_valid = 0;

    // cfg_load beats a matching sample on the same edge
    cfg_load = 1; cfg_pattern = 8'h01; cfg_len = 4'd1; cfg_overlap = 1;
    tick();
    cfg_load = 0; seq_valid = 1; seq_in = 1;
    tick();
    check("pre_load_cnt", 0, 32'(det_count), 32'd1);
    cfg_load = 1;
    tick();
    check("load_drop_det", 0, 32'(det_o), 32'd0);
    check("load_drop_cnt", 0, 32'(det_count), 32'd0);
    cfg_load = 0;
    tick();
    check("after_load_det", 0, 32'(det_o), 32'd1);
    check("after_load_cnt", 0, 32'(det_count), 32'd1);
    seq_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
